// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one full-subtractor step per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [CW-1:0] r_cnt;
    logic r_br, r_amsb, r_bmsb, r_bout, r_ovf;
    logic w_d, w_br, w_last;
    assign w_d    = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign diff   = r_diff;
    assign bout   = r_bout;
    assign ovf    = r_ovf;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    always_comb begin
        w_next    = IDLE;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_next   = in_valid ? RUN : IDLE;
            end
            RUN: begin
                busy   = 1'b1;
                w_next = w_last ? DONE : RUN;
            end
            DONE: begin
                out_valid = 1'b1;
                w_next    = out_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
    end
    // result bits refill r_a from the MSB end as the minuend drains out of its LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_br   <= bin;
            r_cnt  <= '0;
            r_amsb <= a[WIDTH-1];
            r_bmsb <= b[WIDTH-1];
        end else if (r_state == RUN) begin
            r_a   <= {w_d, r_a[WIDTH-1:1]};
            r_b   <= r_b >> 1;
            r_br  <= w_br;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= {w_d, r_a[WIDTH-1:1]};
                r_bout <= w_br;
                r_ovf  <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations scored against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, bout, ovf, busy;
    logic [W-1:0] diff;
    int checks = 0, errors = 0;
    logic [W+1:0] q[$];
    logic [W+1:0] mon_e;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int d;
        logic [W-1:0] r;
        d = int'(x) - int'(y) - int'(c);
        r = d[W-1:0];
        return {r, d < 0, (x[W-1] != y[W-1]) && (r[W-1] != x[W-1])};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got diff=%0h with nothing outstanding", diff);
            end else begin
                mon_e = q.pop_front();
                chk("diff", diff, mon_e[W+1:2]);
                chk("bout", bout, mon_e[1]);
                chk("ovf", ovf, mon_e[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready_wait", in_ready, 1);
        a = x; b = y; bin = c; in_valid = 1'b1;
        q.push_back(model(x, y, c));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 4 * W) begin
            tick();
            n++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic ack(input int stall);
        out_ready = 1'b0;
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W+1:0] e;
        logic [W-1:0] lo, hi;
        logic br;
        logic [15:0] full;
        int n, nb;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(8'h05, 8'h03, 1'b0);
        n = 0; nb = 0;
        while (!out_valid && n < 4 * W) begin
            if (busy) nb++;
            tick();
            n++;
        end
        chk("latency", n, W);
        chk("busy_cycles", nb, W);
        ack(0);
        chk("post_ack_in_ready", in_ready, 1);
        chk("post_ack_out_valid", out_valid, 0);
        send(8'h03, 8'h05, 1'b0); wait_valid(); ack(1);
        send(8'h00, 8'h00, 1'b1); wait_valid(); ack(0);
        send(8'h80, 8'h01, 1'b0); wait_valid(); ack(2);
        send(8'h7F, 8'hFF, 1'b0); wait_valid(); ack(0);
        e = model(8'h3C, 8'h0F, 1'b1);
        out_ready = 1'b0;
        send(8'h3C, 8'h0F, 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            in_valid = (i % 2 == 0);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_diff", diff, e[W+1:2]);
            chk("bp_bout", bout, e[1]);
            chk("bp_ovf", ovf, e[0]);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        tick();
        chk("bp_no_capture", busy, 0);
        out_ready = 1'b1;
        send(8'hAA, 8'h55, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_bout", bout, 0);
        chk("mid_rst_ovf", ovf, 0);
        q.delete(q.size() - 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(8'h10, 8'h01, 1'b0); wait_valid(); ack(0);
        send(8'h00, 8'h01, 1'b0); wait_valid();
        lo = diff; br = bout;
        ack(0);
        send(8'h12, 8'h00, br); wait_valid();
        hi = diff;
        ack(0);
        full = 16'h1200 - 16'h0001;
        chk("chain16", {hi, lo}, full);
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom);
            send(W'($urandom), W'($urandom), 1'($urandom));
            wait_valid();
            ack($urandom_range(0, 2));
        end
        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
